acc_cpu_core: RTL and testbench

//  Parametrised multi-cycle accumulator CPU: fetch/decode/execute FSM, accumulator,

---
 rtl/acc_cpu_core_if.sv | 23 ++
 rtl/acc_cpu_core.sv | 172 +++++++++++++++++
 tb/tb_acc_cpu_core.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_cpu_core_if.sv
// Instruction-fetch port of acc_cpu_core: req/addr from the core, valid/data from memory.
interface acc_cpu_core_if #(
   parameter int unsigned PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_valid;
   logic [7:0]      imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_valid,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_valid,
      output imem_data
   );
endinterface

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator CPU (FETCH -> DECODE -> EXEC, HLT -> HALT).
// Instruction = opcode[7:4], operand[3:0]. Optional macro ACC_SHIFT_EN enables
// opcodes B (SHL) and C (SHR); without it they execute as illegal NOPs.
module acc_cpu_core #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NREG   = 16,
   parameter int unsigned PC_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   acc_cpu_core_if.master        imem,
   output logic [DATA_W-1:0]     acc_out,
   output logic [PC_W-1:0]       pc_out,
   output logic                  zero,
   output logic                  carry,
   output logic                  halted,
   output logic                  illegal
);

   // Bits of a register value that reach the PC on a jump.
   localparam int unsigned CW = (DATA_W < PC_W) ? DATA_W : PC_W;
   localparam logic [PC_W-1:0] PcOne = {{(PC_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;

   state_e            state_q, state_d;
   logic [7:0]        ir_q, ir_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] opnd_q, opnd_d;
   logic              z_q, z_d;
   logic              c_q, c_d;
   logic              ill_q, ill_d;
   logic [DATA_W-1:0] regs_q [NREG];

   logic              reg_we;
   logic              acc_wr;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] imm;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [PC_W-1:0]   tgt;

   // Register-file read; operand indices >= NREG read as zero.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NREG; i++) begin
         if (ir_q[3:0] == 4'(i)) rd_val = regs_q[i];
      end
   end

   // Next-state, datapath and flag update.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      z_d     = z_q;
      c_d     = c_q;
      ill_d   = 1'b0;
      reg_we  = 1'b0;
      acc_wr  = 1'b0;

      sum       = {1'b0, acc_q} + {1'b0, opnd_q};
      diff      = {1'b0, acc_q} - {1'b0, opnd_q};
      imm       = '0;
      imm[3:0]  = ir_q[3:0];
      tgt       = '0;
      tgt[CW-1:0] = opnd_q[CW-1:0];

      unique case (state_q)
         StFetch: begin
            if (imem.imem_valid) begin
               ir_d    = imem.imem_data;
               state_d = StDecode;
            end
         end
         StDecode: begin
            opnd_d  = rd_val;
            state_d = StExec;
         end
         StExec: begin
            state_d = StFetch;
            pc_d    = pc_q + PcOne;
            case (ir_q[7:4])
               4'h0: ;
               4'h1: begin acc_d = imm;            acc_wr = 1'b1; end
               4'h2: begin acc_d = opnd_q;         acc_wr = 1'b1; end
               4'h3: reg_we = 1'b1;
               4'h4: begin
                  acc_d  = sum[DATA_W-1:0];
                  c_d    = sum[DATA_W];
                  acc_wr = 1'b1;
               end
               4'h5: begin
                  acc_d  = diff[DATA_W-1:0];
                  c_d    = diff[DATA_W];
                  acc_wr = 1'b1;
               end
               4'h6: begin acc_d = acc_q & opnd_q; acc_wr = 1'b1; end
               4'h7: begin acc_d = acc_q ^ opnd_q; acc_wr = 1'b1; end
               4'h8: pc_d = tgt;
               4'h9: if (z_q) pc_d = tgt;
               4'hA: if (c_q) pc_d = tgt;
`ifdef ACC_SHIFT_EN
               4'hB: begin
                  acc_d  = {acc_q[DATA_W-2:0], 1'b0};
                  c_d    = acc_q[DATA_W-1];
                  acc_wr = 1'b1;
               end
               4'hC: begin
                  acc_d  = {1'b0, acc_q[DATA_W-1:1]};
                  c_d    = acc_q[0];
                  acc_wr = 1'b1;
               end
`endif
               4'hF: begin
                  // HLT keeps PC on its own address.
                  pc_d    = pc_q;
                  state_d = StHalt;
               end
               default: ill_d = 1'b1;
            endcase
         end
         StHalt: ;
      endcase

      if (acc_wr) z_d = (acc_d == '0);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StFetch;
         ir_q    <= '0;
         pc_q    <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         ill_q   <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         z_q     <= z_d;
         c_q     <= c_d;
         ill_q   <= ill_d;
         // STR to an index >= NREG matches no entry and is dropped.
         for (int i = 0; i < NREG; i++) begin
            if (reg_we && ir_q[3:0] == 4'(i)) regs_q[i] <= acc_q;
         end
      end
   end

   // Port outputs; the fetch request is masked while reset is held.
   always_comb begin
      imem.imem_req  = (state_q == StFetch) && reset;
      imem.imem_addr = pc_q;
      acc_out        = acc_q;
      pc_out         = pc_q;
      zero           = z_q;
      carry          = c_q;
      halted         = (state_q == StHalt);
      illegal        = ill_q;
   end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core: an instruction-level model predicts the
// architectural state after each fetched instruction; a monitor checks it at retirement.
module tb_acc_cpu_core;

   localparam int unsigned DW = 8;
   localparam int unsigned PW = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   acc_cpu_core_if #(.PC_W(PW)) imem ();

   logic [DW-1:0] acc_out;
   logic [PW-1:0] pc_out;
   logic          zero, carry, halted, illegal;

   acc_cpu_core #(.DATA_W(DW), .NREG(16), .PC_W(PW)) dut (
      .clk     (clk),
      .reset   (reset),
      .imem    (imem),
      .acc_out (acc_out),
      .pc_out  (pc_out),
      .zero    (zero),
      .carry   (carry),
      .halted  (halted),
      .illegal (illegal)
   );

   typedef struct {
      int acc;
      int pc;
      int z;
      int c;
      int ill;
      int halt;
   } exp_t;

   exp_t       sbq[$];
   int         n_total = 0;
   int         n_bad = 0;
   int         retired = 0;
   logic [7:0] mem [256];

   int m_acc, m_pc, m_z, m_c, m_halt;
   int m_r [16];
   int wait_left = 0;
   int max_wait = 0;
   int hc;

   logic first_fetch = 1'b1;
   logic prev_req = 1'b0;
   logic prev_halt = 1'b0;

   task automatic chk(input string name, input int act, input int exp_v);
      n_total++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   function automatic void model_reset();
      m_acc = 0; m_pc = 0; m_z = 0; m_c = 0; m_halt = 0;
      for (int i = 0; i < 16; i++) m_r[i] = 0;
   endfunction

   // Architectural effect of one instruction, in plain integer arithmetic.
   function automatic exp_t model_step(input logic [7:0] ins);
      exp_t e;
      int   op, a, rv, npc, ill;
      op  = int'(ins[7:4]);
      a   = int'(ins[3:0]);
      rv  = m_r[a];
      npc = (m_pc + 1) % 256;
      ill = 0;
      case (op)
         0: ;
         1: begin m_acc = a; m_z = (m_acc == 0); end
         2: begin m_acc = rv; m_z = (m_acc == 0); end
         3: m_r[a] = m_acc;
         4: begin
            m_c = (m_acc + rv > 255);
            m_acc = (m_acc + rv) % 256;
            m_z = (m_acc == 0);
         end
         5: begin
            m_c = (m_acc < rv);
            m_acc = (m_acc - rv + 256) % 256;
            m_z = (m_acc == 0);
         end
         6: begin m_acc = m_acc & rv; m_z = (m_acc == 0); end
         7: begin m_acc = m_acc ^ rv; m_z = (m_acc == 0); end
         8: npc = rv;
         9: if (m_z != 0) npc = rv;
         10: if (m_c != 0) npc = rv;
`ifdef ACC_SHIFT_EN
         11: begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; m_z = (m_acc == 0); end
         12: begin m_c = m_acc % 2; m_acc = m_acc / 2; m_z = (m_acc == 0); end
`endif
         15: begin m_halt = 1; npc = m_pc; end
         default: ill = 1;
      endcase
      m_pc   = npc;
      e.acc  = m_acc;
      e.pc   = m_pc;
      e.z    = m_z;
      e.c    = m_c;
      e.ill  = ill;
      e.halt = m_halt;
      return e;
   endfunction

   // Memory side of the fetch port for the current cycle.
   task automatic drive_cycle();
      if (imem.imem_req) begin
         chk("fetch_addr", int'(imem.imem_addr), m_pc);
         if (wait_left > 0) begin
            imem.imem_valid = 1'b0;
            imem.imem_data  = 8'($urandom);
            wait_left--;
         end else begin
            imem.imem_valid = 1'b1;
            imem.imem_data  = mem[m_pc];
            sbq.push_back(model_step(mem[m_pc]));
            wait_left = $urandom_range(0, max_wait);
         end
      end else begin
         // Stray valid pulses outside FETCH must be ignored.
         imem.imem_valid = 1'($urandom_range(0, 1));
         imem.imem_data  = 8'($urandom);
      end
   endtask

   // Reset for two cycles, release, then serve fetches for ncyc cycles.
   task automatic run_prog(input int ncyc, input int maxw, output int hcyc);
      chk("pending_at_reset", int'(sbq.size() > 1), 0);
      max_wait = maxw;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1 reset = 1'b0;
         sbq.delete();
         model_reset();
         #1 drive_cycle();
      end
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("rst_acc", int'(acc_out), 0);
      chk("rst_pc", int'(pc_out), 0);
      chk("rst_zero", int'(zero), 0);
      chk("rst_carry", int'(carry), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_illegal", int'(illegal), 0);
      chk("rst_req", int'(imem.imem_req), 1);
      wait_left = $urandom_range(0, maxw);
      hcyc = -1;
      for (int k = 0; k < ncyc; k++) begin
         if (halted && hcyc < 0) hcyc = k;
         drive_cycle();
         @(posedge clk);
         #2;
      end
   endtask

   // Monitor: a new FETCH or entry into HALT retires the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            first_fetch = 1'b1;
            prev_req    = 1'b0;
            prev_halt   = 1'b0;
         end else begin
            if (imem.imem_req && !prev_req) begin
               if (first_fetch) begin
                  first_fetch = 1'b0;
               end else if (sbq.size() == 0) begin
                  chk("retire_unexpected", 1, 0);
               end else begin
                  e = sbq.pop_front();
                  retired++;
                  chk("ret_halt", 0, e.halt);
                  chk("ret_acc", int'(acc_out), e.acc);
                  chk("ret_pc", int'(pc_out), e.pc);
                  chk("ret_zero", int'(zero), e.z);
                  chk("ret_carry", int'(carry), e.c);
                  chk("ret_illegal", int'(illegal), e.ill);
               end
            end else if (illegal) begin
               chk("illegal_pulse_len", int'(illegal), 0);
            end
            if (halted && !prev_halt) begin
               if (sbq.size() == 0) begin
                  chk("halt_unexpected", 1, 0);
               end else begin
                  e = sbq.pop_front();
                  retired++;
                  chk("hlt_halt", 1, e.halt);
                  chk("hlt_pc", int'(pc_out), e.pc);
                  chk("hlt_acc", int'(acc_out), e.acc);
                  chk("hlt_illegal", int'(illegal), 0);
               end
            end
            if (halted && imem.imem_req) chk("req_in_halt", 1, 0);
            prev_req  = imem.imem_req;
            prev_halt = halted;
         end
      end
   end

   initial begin
      imem.imem_valid = 1'b0;
      imem.imem_data  = 8'h00;

      // LDI 5; STR 2; LDI 3; ADD 2; HLT at zero wait.
      for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
      mem[0] = 8'h15; mem[1] = 8'h32; mem[2] = 8'h13; mem[3] = 8'h42;
      run_prog(30, 0, hc);
      chk("t1_halt_cycle", hc, 15);
      chk("t1_acc", int'(acc_out), 8);
      chk("t1_pc", int'(pc_out), 4);
      chk("t1_zero", int'(zero), 0);
      chk("t1_carry", int'(carry), 0);

      // LDI F; STR 1; LDI 1; SUB 1; XOR 0; HLT.
      for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
      mem[0] = 8'h1F; mem[1] = 8'h31; mem[2] = 8'h11; mem[3] = 8'h51; mem[4] = 8'h70;
      run_prog(60, 2, hc);
      chk("t2_acc", int'(acc_out), 'hF2);
      chk("t2_carry", int'(carry), 1);
      chk("t2_zero", int'(zero), 0);

      // R3 = 0x10; JZ 3 taken; JC 3 not taken; HLT at 0x11.
      for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
      mem[0] = 8'h18; mem[1] = 8'h33; mem[2] = 8'h43; mem[3] = 8'h33;
      mem[4] = 8'h10; mem[5] = 8'h93; mem[16] = 8'hA3; mem[17] = 8'hF0;
      run_prog(60, 1, hc);
      chk("t3_pc", int'(pc_out), 'h11);
      chk("t3_halted", int'(halted), 1);

      // All NOPs: PC walks through 0xFF and wraps to 0.
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      run_prog(820, 0, hc);
      chk("wrap_pc", int'(pc_out), 17);

      // Build ACC=0x81, then opcode B.
      for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
      mem[0] = 8'h11; mem[1] = 8'h32; mem[2] = 8'h18; mem[3] = 8'h31;
      mem[4] = 8'h41; mem[5] = 8'h31; mem[6] = 8'h41; mem[7] = 8'h31;
      mem[8] = 8'h41; mem[9] = 8'h31; mem[10] = 8'h41; mem[11] = 8'h42;
      mem[12] = 8'hB0;
      run_prog(100, 1, hc);
`ifdef ACC_SHIFT_EN
      chk("t6_acc", int'(acc_out), 'h02);
      chk("t6_carry", int'(carry), 1);
`else
      chk("t6_acc", int'(acc_out), 'h81);
      chk("t6_carry", int'(carry), 0);
`endif
      chk("t6_pc", int'(pc_out), 13);

      // Random programs with random wait states and random reset points.
      for (int p = 0; p < 40; p++) begin
         for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
         run_prog($urandom_range(20, 400), $urandom_range(0, 5), hc);
      end

      chk("pending_final", int'(sbq.size() > 1), 0);
      chk("retired_enough", int'(retired > 100), 1);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
